// File: rtl/vicii_sync_pkg.sv
// Shared types and per-chip timing constants for the composite sync sequencer.
// Widths are in pixels, start lines in raster lines.
package vicii_sync_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PRE_EQ  = 2'd1,
        VSYNC   = 2'd2,
        POST_EQ = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        CHIP6567R8   = 2'd0,
        CHIP6567R56A = 2'd1,
        CHIP6569R1   = 2'd2,
        CHIP6569R3   = 2'd3
    } chip_t;

    typedef struct packed {
        logic [9:0] h2;
        logic [9:0] hs;
        logic [9:0] eq;
        logic [9:0] se;
    } pulse_consts_t;

    typedef struct packed {
        pulse_consts_t pulse;
        logic [8:0]    vs0;
    } sync_consts_t;

    localparam int EQ_LINES_DEFAULT = 3;
    localparam int VS_LINES_DEFAULT = 3;

    function automatic pulse_consts_t pulse_consts(input chip_t chip);
        pulse_consts_t c;
        case (chip)
            CHIP6567R8:   c = '{h2: 10'd260, hs: 10'd38, eq: 10'd19, se: 10'd224};
            CHIP6567R56A: c = '{h2: 10'd256, hs: 10'd37, eq: 10'd18, se: 10'd220};
            default:      c = '{h2: 10'd252, hs: 10'd37, eq: 10'd18, se: 10'd217};
        endcase
        return c;
    endfunction

    function automatic logic [8:0] start_line(input chip_t chip);
        logic [8:0] l;
        case (chip)
            CHIP6567R8,
            CHIP6567R56A: l = 9'd14;
            default:      l = 9'd300;
        endcase
        return l;
    endfunction

    function automatic sync_consts_t sync_consts(input chip_t chip);
        sync_consts_t c;
        c.pulse = pulse_consts(chip);
        c.vs0   = start_line(chip);
        return c;
    endfunction

endpackage

// File: rtl/sync_pulse_shaper.sv
// Combinational sync level for one pixel: single pulse on normal lines,
// two half-line pulses on equalization and serrated vsync lines.
module sync_pulse_shaper
    import vicii_sync_pkg::*;
(
    input  logic [1:0] state,
    input  logic [1:0] chip,
    input  logic [9:0] raster_x,
    output logic       pulse
);

    pulse_consts_t c;
    logic [9:0]    width;
    logic [9:0]    second_end;
    logic          split;

    always_comb begin
        c     = pulse_consts(chip_t'(chip));
        width = c.hs;
        split = 1'b0;
        case (seq_state_t'(state))
            NORMAL: begin
                width = c.hs;
                split = 1'b0;
            end
            PRE_EQ, POST_EQ: begin
                width = c.eq;
                split = 1'b1;
            end
            VSYNC: begin
                width = c.se;
                split = 1'b1;
            end
        endcase
        second_end = c.h2 + width;
        pulse = (raster_x < width) ||
                (split && (raster_x >= c.h2) && (raster_x < second_end));
    end

endmodule

// File: rtl/sync_sequencer.sv
// Vertical sync sequencer: picks the pulse shape at each line start and
// registers composite sync from the raster position.
//
//   state   | meaning
//   NORMAL  | regular lines, single hsync pulse
//   PRE_EQ  | equalization lines before vsync
//   VSYNC   | serrated vertical sync lines
//   POST_EQ | equalization lines after vsync
module sync_sequencer
    import vicii_sync_pkg::*;
#(
    parameter int EQ_LINES = EQ_LINES_DEFAULT,
    parameter int VS_LINES = VS_LINES_DEFAULT
) (
    input  logic       clk_dot4x,
    input  logic       rst_n,
    input  logic       dot_tick,
    input  logic [1:0] chip,
    input  logic [9:0] raster_x,
    input  logic [8:0] raster_line,
    output logic       csync,
    output logic       vsync_active,
    output logic       eq_active,
    output logic [1:0] seq_state
);

    localparam logic [1:0] EQ_LAST = 2'(EQ_LINES - 1);
    localparam logic [1:0] VS_LAST = 2'(VS_LINES - 1);

    seq_state_t state, state_nxt;
    chip_t      chip_l, chip_nxt;
    logic [1:0] lc, lc_nxt;
    logic       line_start;
    logic       pulse;

    assign line_start = dot_tick && (raster_x == 10'd0);

    always_comb begin
        state_nxt = state;
        lc_nxt    = lc;
        chip_nxt  = chip_l;
        if (line_start) begin
            lc_nxt = lc + 2'd1;
            case (state)
                NORMAL: begin
                    if (raster_line == start_line(chip_t'(chip))) begin
                        state_nxt = PRE_EQ;
                        lc_nxt    = 2'd0;
                    end
                end
                PRE_EQ: begin
                    if (lc == EQ_LAST) begin
                        state_nxt = VSYNC;
                        lc_nxt    = 2'd0;
                    end
                end
                VSYNC: begin
                    if (lc == VS_LAST) begin
                        state_nxt = POST_EQ;
                        lc_nxt    = 2'd0;
                    end
                end
                POST_EQ: begin
                    if (lc == EQ_LAST) begin
                        state_nxt = NORMAL;
                        lc_nxt    = 2'd0;
                    end
                end
            endcase
            // A chip change only lands on a line that starts or stays in NORMAL,
            // so a running sequence keeps its widths to the end.
            if ((state == NORMAL) || (state_nxt == NORMAL)) begin
                chip_nxt = chip_t'(chip);
            end
        end
    end

    // Shape follows the next state so the first pixel of a line has the new shape.
    sync_pulse_shaper u_shaper (
        .state    (state_nxt),
        .chip     (chip_nxt),
        .raster_x (raster_x),
        .pulse    (pulse)
    );

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NORMAL;
            lc           <= 2'd0;
            chip_l       <= CHIP6567R8;
            csync        <= 1'b0;
            vsync_active <= 1'b0;
            eq_active    <= 1'b0;
        end else if (dot_tick) begin
            state        <= state_nxt;
            lc           <= lc_nxt;
            chip_l       <= chip_nxt;
            csync        <= pulse;
            vsync_active <= (state_nxt == VSYNC);
            eq_active    <= (state_nxt == PRE_EQ) || (state_nxt == POST_EQ);
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_sync_sequencer.sv
// Scoreboard bench for sync_sequencer: stimulus pushes expected outputs,
// a monitor pops and compares one entry per dot_tick.
module tb_sync_sequencer;

    logic       clk_dot4x = 1'b0;
    logic       rst_n = 1'b0;
    logic       dot_tick = 1'b0;
    logic [1:0] chip = 2'd0;
    logic [9:0] raster_x = 10'd0;
    logic [8:0] raster_line = 9'd0;
    logic       csync;
    logic       vsync_active;
    logic       eq_active;
    logic [1:0] seq_state;

    sync_sequencer dut (
        .clk_dot4x    (clk_dot4x),
        .rst_n        (rst_n),
        .dot_tick     (dot_tick),
        .chip         (chip),
        .raster_x     (raster_x),
        .raster_line  (raster_line),
        .csync        (csync),
        .vsync_active (vsync_active),
        .eq_active    (eq_active),
        .seq_state    (seq_state)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    logic       tick_seen;
    logic [4:0] e;

    // cfg index: 0 = 6567R8, 1 = 6567R56A, 2 = 6569
    int H2 [3] = '{260, 256, 252};
    int HS [3] = '{38, 37, 37};
    int EQW[3] = '{19, 18, 18};
    int SEW[3] = '{224, 220, 217};
    int probes[$] = '{17, 18, 19, 20, 36, 37, 38, 39, 216, 217, 218, 219, 220, 221,
                      223, 224, 225, 251, 252, 253, 255, 256, 257, 259, 260, 261,
                      268, 269, 270, 271, 273, 274, 275, 276, 277, 278, 279, 280,
                      468, 469, 472, 473, 475, 476, 477, 479, 483, 484, 485, 519};

    function automatic logic exp_pulse(int st, int cfg, int x);
        int w;
        if (st == 0) return x < HS[cfg];
        w = (st == 2) ? SEW[cfg] : EQW[cfg];
        return (x < w) || (x >= H2[cfg] && x < H2[cfg] + w);
    endfunction

    function automatic int sched(int line, int vs0);
        int d;
        d = line - vs0;
        if (d >= 0 && d <= 2) return 1;
        if (d >= 3 && d <= 5) return 2;
        if (d >= 6 && d <= 8) return 3;
        return 0;
    endfunction

    task automatic send(int x, int line, int chp, int st, int cfg);
        @(negedge clk_dot4x);
        dot_tick    = 1'b1;
        raster_x    = 10'(x);
        raster_line = 9'(line);
        chip        = 2'(chp);
        exp_q.push_back({exp_pulse(st, cfg, x), st == 2, (st == 1 || st == 3), 2'(st)});
    endtask

    task automatic run_line(int line, int chp, int st, int cfg);
        send(0, line, chp, st, cfg);
        foreach (probes[i]) send(probes[i], line, chp, st, cfg);
    endtask

    task automatic idle(int n);
        @(negedge clk_dot4x);
        dot_tick = 1'b0;
        repeat (n) @(negedge clk_dot4x);
    endtask

    task automatic chk(string name, logic [4:0] got, logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (csync,vsync,eq,state)", name, got, exp);
        end
    endtask

    always begin
        @(posedge clk_dot4x);
        tick_seen = rst_n && dot_tick;
        #2;
        if (tick_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow line=%0d x=%0d", raster_line, raster_x);
            end else begin
                e = exp_q.pop_front();
                if ({csync, vsync_active, eq_active, seq_state} !== e) begin
                    errors++;
                    $display("FAIL sb_out line=%0d x=%0d got=%b exp=%b (csync,vsync,eq,state)",
                             raster_line, raster_x,
                             {csync, vsync_active, eq_active, seq_state}, e);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_dot4x);
            dot_tick    = 1'($urandom_range(0, 1));
            raster_x    = 10'($urandom_range(0, 1023));
            raster_line = 9'($urandom_range(0, 511));
            chip        = 2'($urandom_range(0, 3));
            #1 chk("reset_hold", {csync, vsync_active, eq_active, seq_state}, 5'd0);
        end
        @(negedge clk_dot4x);
        dot_tick = 1'b0; chip = 2'd0; raster_x = 10'd0; raster_line = 9'd5;
        rst_n = 1'b1;

        // One full NORMAL R8 line
        for (int x = 0; x < 520; x++) send(x, 5, 0, 0, 0);

        // R8 frame sweep
        for (int l = 0; l <= 262; l++) run_line(l, 0, sched(l, 14), 0);

        // PAL 6569R3 sequence around line 300
        for (int l = 295; l <= 312; l++) run_line(l, 3, sched(l, 300), 2);

        // Chip change from R8 to 6569 during VSYNC line 18
        for (int l = 10; l <= 25; l++) begin
            if (l == 18) begin
                send(0, 18, 0, 2, 0);
                foreach (probes[i]) send(probes[i], 18, 2, 2, 0);
            end else begin
                run_line(l, (l < 18) ? 0 : 2, sched(l, 14), (l <= 22) ? 0 : 2);
            end
        end

        // Asynchronous reset during line 18
        for (int l = 10; l <= 17; l++) run_line(l, 0, sched(l, 14), 0);
        send(0, 18, 0, 2, 0);
        send(100, 18, 0, 2, 0);
        idle(3);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", {csync, vsync_active, eq_active, seq_state}, 5'd0);
        @(negedge clk_dot4x);
        rst_n = 1'b1;
        for (int l = 18; l <= 25; l++) run_line(l, 0, 0, 0);
        for (int l = 12; l <= 16; l++) run_line(l, 0, sched(l, 14), 0);

        // dot_tick low for 5 clocks mid VSYNC line 17
        send(0, 17, 0, 2, 0);
        send(10, 17, 0, 2, 0);
        @(negedge clk_dot4x);
        dot_tick = 1'b0; raster_x = 10'd0; raster_line = 9'd300; chip = 2'd3;
        repeat (5) begin
            @(posedge clk_dot4x);
            #3 chk("tick_hold", {csync, vsync_active, eq_active, seq_state}, 5'b11010);
        end
        send(11, 17, 0, 2, 0);
        foreach (probes[i]) send(probes[i], 17, 0, 2, 0);
        for (int l = 18; l <= 23; l++) run_line(l, 0, sched(l, 14), 0);

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
